// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the 16-bit instruction memory.
// Packs big-endian byte pairs into words, writes them from BASE_ADDR upward,
// checks a trailing XOR checksum and then releases the core via cpu_run.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   byte_data/valid incoming stream byte and its qualifier
//   byte_ready      loader accepts a byte this cycle (low only once done)
//   start           single-cycle pulse that re-arms the loader from DONE
//   mem_we/addr/    one-cycle instruction-memory write port
//   mem_wdata
//   words_loaded    words written since the current load began
//   cpu_run         memory image valid, core may fetch
//   err             checksum mismatch on the last load
module imem_loader #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [15:0]       words_loaded,
    output logic              cpu_run,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        hi_q, hi_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [15:0]       words_q, words_d;
    logic              cpu_run_q, cpu_run_d;
    logic              err_q, err_d;
    logic              accept;

    assign byte_ready   = (state_q != S_DONE);
    assign accept       = byte_valid && byte_ready;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign cpu_run      = cpu_run_q;
    assign err          = err_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        csum_d      = csum_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        cpu_run_d   = cpu_run_q;
        err_d       = err_q;
        unique case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    csum_d     = 8'h00;
                    if ({len_q[15:8], byte_data} != 16'h0000)
                        state_d = S_DATA_HI;
                    else
                        state_d = S_CSUM;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = byte_data;
                    csum_d  = csum_q ^ byte_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    csum_d      = csum_q ^ byte_data;
                    mem_we_d    = 1'b1;
                    // words_q is the index of the word being written
                    mem_addr_d  = BASE + ADDR_W'(words_q);
                    mem_wdata_d = {hi_q, byte_data};
                    words_d     = words_q + 16'd1;
                    if (words_d == len_q)
                        state_d = S_CSUM;
                    else
                        state_d = S_DATA_HI;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    cpu_run_d = (byte_data == csum_q);
                    err_d     = (byte_data != csum_q);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    cpu_run_d = 1'b0;
                    err_d     = 1'b0;
                    words_d   = 16'h0000;
                    state_d   = S_LEN_HI;
                end
            end
            default: state_d = S_LEN_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LEN_HI;
            len_q       <= 16'h0000;
            csum_q      <= 8'h00;
            hi_q        <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= 16'h0000;
            words_q     <= 16'h0000;
            cpu_run_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            hi_q        <= hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            cpu_run_q   <= cpu_run_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
// Small address width so that address wrap is reached by short streams.
module tb_imem_loader;

    localparam int AW   = 4;
    localparam int BASE = 0;

    logic          clk;
    logic          rst;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   words_loaded;
    logic          cpu_run;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [15:0]   wl;
    } wr_t;

    wr_t exp_q[$];

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .start        (start),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .words_loaded (words_loaded),
        .cpu_run      (cpu_run),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
                check("wr_count", 32'(words_loaded), 32'(e.wl));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        if (gaps) begin
            int g;
            g = $urandom_range(1, 5);
            for (int i = 0; i < g; i++) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                start      = (i == 0) && ($urandom_range(0, 3) == 0);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = byte_ready;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got byte_ready 0 expected 1");
        end
    endtask

    // Reference: build the stream from the words, queue the expected writes,
    // send it, then compare the final flags once the loader reports done.
    task automatic run_stream(input logic [15:0] w[$], input int csum_ov,
                              input bit corrupt, input bit gaps);
        logic [7:0]  cs;
        logic [7:0]  sent;
        logic [15:0] n;
        bit          good;
        bit          ok;
        n  = 16'(w.size());
        cs = 8'h00;
        foreach (w[i]) begin
            wr_t e;
            cs ^= w[i][15:8] ^ w[i][7:0];
            e.addr = AW'((BASE + i) % (1 << AW));
            e.data = w[i];
            e.wl   = 16'(i + 1);
            exp_q.push_back(e);
        end
        if (csum_ov >= 0)
            sent = 8'(csum_ov);
        else if (corrupt)
            sent = cs ^ 8'($urandom_range(1, 255));
        else
            sent = cs;
        good = (sent == cs);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        foreach (w[i]) begin
            send_byte(w[i][15:8], gaps);
            send_byte(w[i][7:0], gaps);
        end
        send_byte(sent, gaps);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = !byte_ready;
        end
        check("done_reached", 32'(ok), 32'd1);
        check("cpu_run", 32'(cpu_run), 32'(good));
        check("err", 32'(err), 32'(!good));
        check("words_loaded", 32'(words_loaded), 32'(n));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_run", 32'(cpu_run), 32'd0);
        check("start_err", 32'(err), 32'd0);
        check("start_count", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd1);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'(AW'(BASE)));
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_count"}, 32'(words_loaded), 32'd0);
        check({tag, "_run"}, 32'(cpu_run), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        start      = 1'b0;
        #2;
        check_reset_values("rst_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst_idle");
        @(posedge clk);
        #1;

        w = '{16'h3260, 16'h34A0, 16'h0261};
        run_stream(w, -1, 1'b0, 1'b0);
        check("plan_csum_a5", 32'(cpu_run), 32'd1);

        do_start();
        run_stream(w, 8'hA4, 1'b0, 1'b0);

        do_start();
        w = {};
        run_stream(w, -1, 1'b0, 1'b0);

        do_start();
        run_stream(w, 8'h07, 1'b0, 1'b0);

        do_start();
        w = '{16'h3260, 16'h34A0, 16'h0261};
        run_stream(w, -1, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
            check("done_blocks", 32'(byte_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        check("done_sticky_run", 32'(cpu_run), 32'd1);

        do_start();
        w = '{16'h1234};
        run_stream(w, -1, 1'b0, 1'b0);

        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h32, 1'b0);
        rst = 1'b1;
        #2;
        check_reset_values("midload_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        w = '{16'h3260, 16'h34A0, 16'h0261};
        run_stream(w, -1, 1'b0, 1'b0);

        for (int s = 0; s < 8; s++) begin
            int n;
            do_start();
            n = $urandom_range(0, 40);
            w = {};
            for (int k = 0; k < n; k++)
                w.push_back(16'($urandom));
            run_stream(w, -1, ($urandom_range(0, 3) == 0), s[0]);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer that fills the 16-bit instruction memory before the core starts fetching; fetch remains the memory's only reader.
- Accepts a byte stream over a valid/ready handshake (e.g. from a UART receiver) and packs big-endian byte pairs into instruction words.
- Writes the words to consecutive addresses, verifies an XOR checksum, then releases the core via cpu_run.

Parameters:
ADDR_W, 16, instruction memory address width; addresses wrap modulo 2^ADDR_W.
BASE_ADDR, 0, address at which the first loaded word is written.

Ports:
clk  input  1  single system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
byte_data  input  8  incoming stream byte.
byte_valid  input  1  byte_data is valid this cycle.
byte_ready  output  1  loader accepts a byte this cycle.
start  input  1  single-cycle pulse; restarts loading, honoured only in DONE.
mem_we  output  1  one-cycle instruction-memory write strobe.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  16  write data.
words_loaded  output  16  count of words written since the last load began.
cpu_run  output  1  high = memory valid; core may leave reset and fetch.
err  output  1  high = checksum mismatch on the last load.

Behaviour:
- Reset (async, active-high): state LEN_HI; byte_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_loaded=0, cpu_run=0, err=0; length, checksum and partial-byte registers cleared.
- A byte is accepted only on a rising edge with byte_valid && byte_ready. Non-accepting cycles change no state.
- Stream format: LEN_H, LEN_L (word count N, 16-bit), then N pairs (HI, LO), then CSUM. CSUM is the XOR of all 2N data bytes; the length bytes are not included.
- States:
  - LEN_HI: accept -> store N[15:8], go to LEN_LO.
  - LEN_LO: accept -> store N[7:0], clear running XOR. Go to DATA_HI if N!=0, otherwise CSUM.
  - DATA_HI: accept -> latch hi byte, XOR into running sum, go to DATA_LO.
  - DATA_LO: accept -> XOR into running sum. Next cycle: mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+index (ADDR_W bits, wraps), mem_wdata={hi,lo}; words_loaded increments in that same cycle. Go to DATA_HI if fewer than N words written, otherwise CSUM.
  - CSUM: accept -> compare byte with running XOR, go to DONE. On the next cycle cpu_run=1 if equal, otherwise err=1.
  - DONE: byte_ready=0. cpu_run/err are sticky. start=1 -> go to LEN_HI; cpu_run, err and words_loaded clear and byte_ready=1 on the following cycle.
- byte_ready is 1 in every state except DONE, including the cycle mem_we is high. Back-to-back bytes every cycle are sustained.
- start outside DONE: ignored.
- N=0: no writes; the checksum byte must equal 0x00.
- N up to 65535: addresses past 2^ADDR_W-1 wrap to 0. words_loaded is 16-bit.
- Reset mid-load: partial word discarded; no write is issued for it; cpu_run stays 0.
- mem_addr and mem_wdata hold their last values while mem_we=0.

Test Plan:
- Reset, then bytes 00 03 32 60 34 A0 02 61 A5 on consecutive cycles -> writes (0,0x3260), (1,0x34A0), (2,0x0261), each a single-cycle mem_we; words_loaded=3; cpu_run=1 one cycle after A5 is accepted; err=0; byte_ready=0.
- Same stream with checksum A4 -> three writes occur; err=1, cpu_run=0.
- Stream 00 00 00 -> no mem_we; cpu_run=1. Stream 00 00 07 -> err=1.
- Valid stream with byte_valid low for 1-5 random cycles between bytes -> identical writes and final flags; mem_we never asserts during gaps.
- After DONE, extra bytes presented with start=0 -> byte_ready=0, no writes. Pulse start, send 00 01 12 34 26 -> cpu_run drops, then write (0,0x1234); words_loaded=1; cpu_run=1.
- Assert rst after LEN and HI byte 32 are accepted -> no write, all outputs at reset values. A fresh full stream then loads correctly from BASE_ADDR.
